pc_fetch: RTL and testbench

PC_FETCH -- requirements
Module: pc_fetch

---
 rtl/pc_fetch_if.sv | 30 +++
 rtl/pc_fetch.sv | 129 ++++++++++++
 tb/tb_pc_fetch.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_if.sv
// Fetch-unit bus: decode handshake, redirect controls, RAM2 read port and fetch status.
// The master modport is the fetch unit; the slave modport is decode plus the RAM2 side.
interface pc_fetch_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              pfi_ready;
    logic              pfi_branch;
    logic [ADDR_W-1:0] pfi_new_addr;
    logic              pfi_int_req;
    logic              pfi_eret;
    logic [DATA_W-1:0] pfi_ram2_data;
    logic [ADDR_W-1:0] pfo_addr;
    logic              pfo_ram2_oe;
    logic [DATA_W-1:0] pfo_instr;
    logic [ADDR_W-1:0] pfo_instr_pc;
    logic              pfo_valid;
    logic [ADDR_W-1:0] pfo_epc;
    logic              pfo_in_isr;

    modport master (
        input  pfi_ready, pfi_branch, pfi_new_addr, pfi_int_req, pfi_eret, pfi_ram2_data,
        output pfo_addr, pfo_ram2_oe, pfo_instr, pfo_instr_pc, pfo_valid, pfo_epc, pfo_in_isr
    );

    modport slave (
        output pfi_ready, pfi_branch, pfi_new_addr, pfi_int_req, pfi_eret, pfi_ram2_data,
        input  pfo_addr, pfo_ram2_oe, pfo_instr, pfo_instr_pc, pfo_valid, pfo_epc, pfo_in_isr
    );
endinterface

// File: rtl/pc_fetch.sv
// Program counter and RAM2 instruction fetch with branch, interrupt and eret redirects.
// Read takes WAIT_CYCLES+1 cycles; instruction held in HOLD until pfi_ready is seen.
module pc_fetch #(
    parameter int                ADDR_W      = 16,
    parameter int                DATA_W      = 16,
    parameter logic [ADDR_W-1:0] RESET_ADDR  = '0,
    parameter logic [ADDR_W-1:0] INT_VECTOR  = 16'h0008,
    parameter int                WAIT_CYCLES = 1
) (
    input  logic       pfi_clk,
    input  logic       pfi_rst,
    pc_fetch_if.master bus
);
    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] epc_q, epc_d;
    logic              in_isr_q, in_isr_d;
    logic              ram2_oe;

    logic              active, handshake, last_beat;
    logic              int_acc, eret_acc, br_acc, redirect;
    logic [ADDR_W-1:0] pc_inc;

    always_comb begin
        active    = (state_q != IDLE);
        handshake = (state_q == HOLD) && valid_q && bus.pfi_ready;
        last_beat = (state_q == FETCH) && (cnt_q == 4'(WAIT_CYCLES));
        pc_inc    = addr_q + 1'b1;
        // eret outside an ISR is simply not a redirect source
        int_acc   = active && bus.pfi_int_req && !in_isr_q;
        eret_acc  = active && bus.pfi_eret && in_isr_q;
        br_acc    = active && bus.pfi_branch;
        redirect  = int_acc || eret_acc || br_acc;
    end

    always_ff @(posedge pfi_clk or negedge pfi_rst) begin
        if (!pfi_rst) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = FETCH;
            FETCH:   if (redirect) state_d = FETCH;
                     else if (last_beat) state_d = HOLD;
            HOLD:    if (redirect || handshake) state_d = FETCH;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ram2_oe = (state_q != FETCH);
    end

    always_comb begin
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        valid_d    = valid_q;
        epc_d      = epc_q;
        in_isr_d   = in_isr_q;
        if (state_q == IDLE) begin
            cnt_d = '0;
        end else if (int_acc) begin
            // a handshake on the same edge has delivered the current PC
            epc_d    = handshake ? pc_inc : addr_q;
            addr_d   = INT_VECTOR;
            in_isr_d = 1'b1;
            valid_d  = 1'b0;
            cnt_d    = '0;
        end else if (eret_acc) begin
            addr_d   = epc_q;
            in_isr_d = 1'b0;
            valid_d  = 1'b0;
            cnt_d    = '0;
        end else if (br_acc) begin
            addr_d  = bus.pfi_new_addr;
            valid_d = 1'b0;
            cnt_d   = '0;
        end else if (last_beat) begin
            instr_d    = bus.pfi_ram2_data;
            instr_pc_d = addr_q;
            valid_d    = 1'b1;
            cnt_d      = '0;
        end else if (state_q == FETCH) begin
            cnt_d = cnt_q + 4'd1;
        end else if (handshake) begin
            addr_d  = pc_inc;
            valid_d = 1'b0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge pfi_clk or negedge pfi_rst) begin
        if (!pfi_rst) begin
            cnt_q      <= '0;
            addr_q     <= RESET_ADDR;
            instr_q    <= '0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
            epc_q      <= '0;
            in_isr_q   <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
            epc_q      <= epc_d;
            in_isr_q   <= in_isr_d;
        end
    end

    assign bus.pfo_addr     = addr_q;
    assign bus.pfo_ram2_oe  = ram2_oe;
    assign bus.pfo_instr    = instr_q;
    assign bus.pfo_instr_pc = instr_pc_q;
    assign bus.pfo_valid    = valid_q;
    assign bus.pfo_epc      = epc_q;
    assign bus.pfo_in_isr   = in_isr_q;
endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: RAM2 modelled as data = address + 0x100.
module tb_pc_fetch;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    pc_fetch_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    pc_fetch #(
        .ADDR_W(16), .DATA_W(16), .RESET_ADDR(16'h0000),
        .INT_VECTOR(16'h0008), .WAIT_CYCLES(1)
    ) dut (
        .pfi_clk(clk),
        .pfi_rst(rst_n),
        .bus    (bus)
    );

    assign bus.pfi_ram2_data = bus.pfo_addr + 16'h0100;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_addr"},   32'(bus.pfo_addr), 32'h0);
        chk({tag, "_oe"},     32'(bus.pfo_ram2_oe), 32'h1);
        chk({tag, "_instr"},  32'(bus.pfo_instr), 32'h0);
        chk({tag, "_ipc"},    32'(bus.pfo_instr_pc), 32'h0);
        chk({tag, "_valid"},  32'(bus.pfo_valid), 32'h0);
        chk({tag, "_epc"},    32'(bus.pfo_epc), 32'h0);
        chk({tag, "_in_isr"}, 32'(bus.pfo_in_isr), 32'h0);
    endtask

    task automatic chk_valid(input string tag, input logic [15:0] pc);
        logic [15:0] exp_instr;
        exp_instr = pc + 16'h0100;
        chk({tag, "_valid"}, 32'(bus.pfo_valid), 32'h1);
        chk({tag, "_ipc"},   32'(bus.pfo_instr_pc), 32'(pc));
        chk({tag, "_instr"}, 32'(bus.pfo_instr), 32'(exp_instr));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.pfi_ready    = 1'b1;
        bus.pfi_branch   = 1'b0;
        bus.pfi_new_addr = '0;
        bus.pfi_int_req  = 1'b0;
        bus.pfi_eret     = 1'b0;

        // reset held across edges
        #12;
        chk_reset("rst");
        #1 rst_n = 1'b1;

        // sequential fetch, ready held high
        tick();
        chk("e1_oe", 32'(bus.pfo_ram2_oe), 32'h0);
        chk("e1_valid", 32'(bus.pfo_valid), 32'h0);
        tick();
        chk("e2_valid", 32'(bus.pfo_valid), 32'h0);
        tick();
        chk_valid("e3", 16'h0000);
        chk("e3_oe", 32'(bus.pfo_ram2_oe), 32'h1);
        tick();
        chk("e4_addr", 32'(bus.pfo_addr), 32'h1);
        chk("e4_valid", 32'(bus.pfo_valid), 32'h0);
        tick(2);
        chk_valid("pc1", 16'h0001);
        tick(9);
        chk_valid("pc4", 16'h0004);

        // stall in HOLD at pc 4
        bus.pfi_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_valid("stall", 16'h0004);
            chk("stall_oe", 32'(bus.pfo_ram2_oe), 32'h1);
            chk("stall_addr", 32'(bus.pfo_addr), 32'h4);
        end
        bus.pfi_ready = 1'b1;
        tick();
        chk("unstall_addr", 32'(bus.pfo_addr), 32'h5);
        chk("unstall_valid", 32'(bus.pfo_valid), 32'h0);

        // branch to 2, then branch to 0x40 on the edge pc 2 would be captured
        bus.pfi_branch = 1'b1;
        bus.pfi_new_addr = 16'h0002;
        tick();
        bus.pfi_branch = 1'b0;
        chk("br2_addr", 32'(bus.pfo_addr), 32'h2);
        tick();
        bus.pfi_branch = 1'b1;
        bus.pfi_new_addr = 16'h0040;
        tick();
        bus.pfi_branch = 1'b0;
        chk("br40_addr", 32'(bus.pfo_addr), 32'h40);
        chk("br40_valid", 32'(bus.pfo_valid), 32'h0);
        chk("br40_ipc", 32'(bus.pfo_instr_pc), 32'h4);
        tick(2);
        chk_valid("pc40", 16'h0040);

        // branch to 7, interrupt with handshake in HOLD
        bus.pfi_branch = 1'b1;
        bus.pfi_new_addr = 16'h0007;
        tick();
        bus.pfi_branch = 1'b0;
        tick(2);
        chk_valid("pc7", 16'h0007);
        bus.pfi_int_req = 1'b1;
        tick();
        chk("int_epc", 32'(bus.pfo_epc), 32'h8);
        chk("int_addr", 32'(bus.pfo_addr), 32'h8);
        chk("int_isr", 32'(bus.pfo_in_isr), 32'h1);
        chk("int_valid", 32'(bus.pfo_valid), 32'h0);
        tick(2);
        chk_valid("nest_ign", 16'h0008);
        chk("nest_isr", 32'(bus.pfo_in_isr), 32'h1);
        chk("nest_epc", 32'(bus.pfo_epc), 32'h8);
        bus.pfi_int_req = 1'b0;
        tick();
        bus.pfi_eret = 1'b1;
        tick();
        bus.pfi_eret = 1'b0;
        chk("eret_addr", 32'(bus.pfo_addr), 32'h8);
        chk("eret_isr", 32'(bus.pfo_in_isr), 32'h0);

        // int + eret + branch together in FETCH of pc 3
        bus.pfi_branch = 1'b1;
        bus.pfi_new_addr = 16'h0003;
        tick();
        chk("br3_addr", 32'(bus.pfo_addr), 32'h3);
        bus.pfi_int_req = 1'b1;
        bus.pfi_eret = 1'b1;
        bus.pfi_new_addr = 16'h0055;
        tick();
        bus.pfi_int_req = 1'b0;
        chk("prio_epc", 32'(bus.pfo_epc), 32'h3);
        chk("prio_addr", 32'(bus.pfo_addr), 32'h8);
        chk("prio_isr", 32'(bus.pfo_in_isr), 32'h1);
        // eret and branch together inside the ISR: eret wins
        tick();
        bus.pfi_eret = 1'b0;
        bus.pfi_branch = 1'b0;
        chk("eret_br_addr", 32'(bus.pfo_addr), 32'h3);
        chk("eret_br_isr", 32'(bus.pfo_in_isr), 32'h0);

        // wrap from 0xFFFF to 0
        bus.pfi_branch = 1'b1;
        bus.pfi_new_addr = 16'hFFFF;
        tick();
        bus.pfi_branch = 1'b0;
        tick(2);
        chk_valid("pcffff", 16'hFFFF);
        tick();
        chk("wrap_addr", 32'(bus.pfo_addr), 32'h0);
        tick(2);
        chk_valid("pc0wrap", 16'h0000);

        // reset pulsed mid-FETCH of pc 1
        tick(2);
        chk("midf_oe", 32'(bus.pfo_ram2_oe), 32'h0);
        chk("midf_addr", 32'(bus.pfo_addr), 32'h1);
        rst_n = 1'b0;
        #1;
        chk_reset("arst");
        tick();
        chk_reset("arst_hold");
        rst_n = 1'b1;
        tick();
        chk("rel_oe", 32'(bus.pfo_ram2_oe), 32'h0);
        chk("rel_addr", 32'(bus.pfo_addr), 32'h0);
        tick(2);
        chk_valid("rel_pc0", 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
